alu_barrel_pipe: RTL and testbench
==================================

# alu_barrel_pipe

Pipelined, parametrised barrel shifter for the lab ALU datapath. It generalises the 4-bit combinational barrel shifter to any power-of-two width N, adds explicit shift amounts, arithmetic and rotate modes, and registers one shift stage per amount bit. A valid/ready handshake on input and output lets it sit between the operand-fetch stage and the ALU result mux with backpressure.

## Interface
Parameters:
- N, 8, data width; power of two, N >= 4.
- LOGN, $clog2(N), derived (localparam); shift-amount width and pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand presented.
- in_ready  output  1  block accepts operand this cycle.
- A  input  N  operand.
- S  input  3  mode select.
- AMT  input  LOGN  shift amount, 0..N-1.
- out_valid  output  1  Z/ZF hold a result.
- out_ready  input  1  consumer accepts result this cycle.
- Z  output  N  shifted result.
- ZF  output  1  zero flag, Z == 0.

## Operation
- Modes (S): 000 PASS; 001 SLL (zero fill); 010 SRL (zero fill); 011 SRA (sign fill from A[N-1]); 100 ROL; 101 ROR; 110/111 reserved, behave as PASS.
- AMT = 0 in any mode: Z = A.
- Pipeline of LOGN stages; stage k (k = 0..LOGN-1) applies a shift of 2^k iff AMT[k] = 1, in the captured mode, and registers data, mode, remaining AMT bits, and a valid bit.
- SRA: sign bit captured at accept and carried with the word; every stage fills with it.
- Rotates: bits leaving one end enter the other; ROL by k equals ROR by N-k.
- Stage LOGN-1 register drives Z, ZF, out_valid directly (no output logic after the flop).
- Advance = !out_valid || out_ready. On advance all stages shift forward one position; otherwise all stages hold.
- in_ready = advance (combinational from out_valid, out_ready). Transfer in when in_valid && in_ready; stage 0 loads valid = in_valid on every advance.
- Bubbles are not compressed; they travel with the pipe.
- Output transfer when out_valid && out_ready. Z/ZF must stay stable while out_valid && !out_ready.
- No FSM beyond per-stage valid bits.

## Timing
- Latency: LOGN cycles from accepting edge to out_valid high, absent stall.
- Throughput: one result per cycle when out_ready held high.
- Reset: all valid bits 0, all data registers 0; out_valid = 0, Z = 0, ZF = 1, in_ready = 1 (after reset, since out_valid = 0).
- Reset mid-operation: in-flight operands discarded; no out_valid until a new operand has traversed LOGN stages after rst deasserts.
- Simultaneous output transfer and input accept in the same cycle: both occur; pipe depth unchanged.
- Stall with pipe full: in_ready low; in_valid ignored; A/S/AMT need not be held by the block.

## Structure
- Mode encodings (PASS, SLL, SRL, SRA, ROL, ROR) as localparams in shared header alu_defs.vh, included by ALU modules and benches.
- Sub-module alu_barrel_stage, parameters N and DIST: combinational shift-by-DIST for one mode plus its pipeline register with hold enable; top instantiates LOGN copies with DIST = 2^k via generate.

## Test plan
- N=8, A=8'b1001_0110: SLL AMT=3 -> 1011_0000; SRL AMT=4 -> 0000_1001; SRA AMT=2 -> 1110_0101; ROR AMT=1 -> 0100_1011; ROL AMT=7 -> 0100_1011; mode 110 AMT=5 -> 1001_0110. Each result appears exactly 3 cycles after accept.
- Exhaustive sweep N=4: all A (16) x AMT (4) x S (8) streamed back-to-back, out_ready=1 -> results match reference model in order, one per cycle, ZF=1 exactly when Z=0.
- Backpressure: out_ready=0, stream 5 operands with in_valid=1 -> only 3 accepted, in_ready low after pipe fills, Z holds first result; raise out_ready -> results emerge in order, none lost or duplicated.
- Bubbles: alternate in_valid 1/0 with random out_ready -> output order and values preserved, out_valid pattern matches accepted count.
- Reset mid-stream: assert rst with 3 operands in flight -> out_valid=0, Z=0, ZF=1 immediately (asynchronous); after release, first new operand appears at out after 3 cycles.
- Parameter check N=16, A=16'h8001: SRA AMT=15 -> 16'hFFFF; ROL AMT=1 -> 16'h0003; latency 4 cycles.

Source files
------------

// File: rtl/alu_barrel_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// a helper that folds reserved modes onto PASS.
package alu_barrel_pipe_pkg;

  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_SLL  = 3'b001;
  localparam logic [2:0] MODE_SRL  = 3'b010;
  localparam logic [2:0] MODE_SRA  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  // Reserved encodings (110/111) behave exactly like PASS, so they are
  // normalised once at capture and the stages only ever see legal modes.
  function automatic logic [2:0] mode_norm(input logic [2:0] s);
    logic [2:0] m;
    case (s)
      MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR: m = s;
      default:                                           m = MODE_PASS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_barrel_pipe_stage.sv
// One barrel-shifter pipeline stage: conditionally shifts by DIST in the
// carried mode (when the matching amount bit is set) and registers the word
// with its side-band (valid, mode, sign, amount, zero flag). Holds when en=0.
module alu_barrel_stage
  import alu_barrel_pipe_pkg::*;
#(
  parameter int N    = 8,
  parameter int DIST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_i,
  input  logic [N-1:0]         data_i,
  input  logic [2:0]           mode_i,
  input  logic                 sign_i,
  input  logic [$clog2(N)-1:0] amt_i,
  output logic                 valid_o,
  output logic [N-1:0]         data_o,
  output logic [2:0]           mode_o,
  output logic                 sign_o,
  output logic [$clog2(N)-1:0] amt_o,
  output logic                 zf_o
);

  localparam int LOGN = $clog2(N);
  localparam int BIT  = $clog2(DIST);

  logic            valid_q;
  logic [N-1:0]    data_q;
  logic [N-1:0]    data_d;
  logic [2:0]      mode_q;
  logic            sign_q;
  logic [LOGN-1:0] amt_q;
  logic            zf_q;
  logic            zf_d;

  // Shift by DIST in the carried mode when this stage's amount bit is set.
  always_comb begin
    data_d = data_i;
    if (amt_i[BIT]) begin
      case (mode_i)
        MODE_SLL: data_d = {data_i[N-1-DIST:0], {DIST{1'b0}}};
        MODE_SRL: data_d = {{DIST{1'b0}}, data_i[N-1:DIST]};
        MODE_SRA: data_d = {{DIST{sign_i}}, data_i[N-1:DIST]};
        MODE_ROL: data_d = {data_i[N-1-DIST:0], data_i[N-1:N-DIST]};
        MODE_ROR: data_d = {data_i[DIST-1:0], data_i[N-1:DIST]};
        default:  data_d = data_i;
      endcase
    end
    zf_d = (data_d == '0);
  end

  // Pipeline register; the zero flag is computed before the flop so the
  // last stage drives ZF with no logic after the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= MODE_PASS;
      sign_q  <= 1'b0;
      amt_q   <= '0;
      zf_q    <= 1'b1;
    end else if (en) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      mode_q  <= mode_i;
      sign_q  <= sign_i;
      amt_q   <= amt_i;
      zf_q    <= zf_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;
  assign sign_o  = sign_q;
  assign amt_o   = amt_q;
  assign zf_o    = zf_q;

endmodule

// File: rtl/alu_barrel_pipe.sv
// Pipelined barrel shifter with valid/ready handshake. LOGN stages, stage k
// shifts by 2^k when AMT[k] is set. The whole pipe advances together when the
// output register is empty or being drained; bubbles travel with the pipe.
module alu_barrel_pipe
  import alu_barrel_pipe_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         A,
  input  logic [2:0]           S,
  input  logic [$clog2(N)-1:0] AMT,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         Z,
  output logic                 ZF
);

  localparam int LOGN = $clog2(N);

  logic            advance;
  logic            v_w  [0:LOGN];
  logic [N-1:0]    d_w  [0:LOGN];
  logic [2:0]      m_w  [0:LOGN];
  logic            s_w  [0:LOGN];
  logic [LOGN-1:0] a_w  [0:LOGN];
  logic            zf_w [1:LOGN];
  logic            unused_tail;
  logic            unused_zf;

  // Global advance: all stages move together, or all hold.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 0 captures the operand; the sign bit travels with the word for SRA.
  assign v_w[0] = in_valid;
  assign d_w[0] = A;
  assign m_w[0] = mode_norm(S);
  assign s_w[0] = A[N-1];
  assign a_w[0] = AMT;

  generate
    for (genvar gi = 0; gi < LOGN; gi++) begin : g_stage
      alu_barrel_stage #(
        .N    (N),
        .DIST (1 << gi)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (advance),
        .valid_i (v_w[gi]),
        .data_i  (d_w[gi]),
        .mode_i  (m_w[gi]),
        .sign_i  (s_w[gi]),
        .amt_i   (a_w[gi]),
        .valid_o (v_w[gi+1]),
        .data_o  (d_w[gi+1]),
        .mode_o  (m_w[gi+1]),
        .sign_o  (s_w[gi+1]),
        .amt_o   (a_w[gi+1]),
        .zf_o    (zf_w[gi+1])
      );
    end
  endgenerate

  // Last stage register drives the outputs directly.
  assign out_valid = v_w[LOGN];
  assign Z         = d_w[LOGN];
  assign ZF        = zf_w[LOGN];

  // Side-band leaving the final stage and intermediate zero flags have no consumer.
  assign unused_tail = ^{m_w[LOGN], s_w[LOGN], a_w[LOGN]};

  // Fold intermediate-stage zero flags together; they have no consumer.
  always_comb begin
    unused_zf = 1'b0;
    for (int i = 1; i < LOGN; i++) begin
      unused_zf = unused_zf ^ zf_w[i];
    end
  end

endmodule

// File: tb/tb_alu_barrel_pipe.sv
// Scoreboard bench for alu_barrel_pipe at N=8, N=4 (exhaustive) and N=16.
module tb_alu_barrel_pipe;
  import alu_barrel_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] z;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t q16[$];
  exp_t e8, e4, e16;
  int acc8 = 0, xfer8 = 0, xfer4 = 0, xfer16 = 0;

  // N=8 instance
  logic       iv8, ir8, ov8, or8, zf8;
  logic [7:0] a8, z8;
  logic [2:0] s8, amt8;
  // N=4 instance
  logic       iv4, ir4, ov4, or4, zf4;
  logic [3:0] a4, z4;
  logic [2:0] s4;
  logic [1:0] amt4;
  // N=16 instance
  logic        iv16, ir16, ov16, or16, zf16;
  logic [15:0] a16, z16;
  logic [2:0]  s16;
  logic [3:0]  amt16;

  alu_barrel_pipe #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .S(s8),
    .AMT(amt8), .out_valid(ov8), .out_ready(or8), .Z(z8), .ZF(zf8));
  alu_barrel_pipe #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .S(s4),
    .AMT(amt4), .out_valid(ov4), .out_ready(or4), .Z(z4), .ZF(zf4));
  alu_barrel_pipe #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .S(s16),
    .AMT(amt16), .out_valid(ov16), .out_ready(or16), .Z(z16), .ZF(zf16));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", nm, cyc);
  endtask

  // Bit-by-bit reference for the exhaustive sweep.
  function automatic logic [15:0] ref_shift(input int n, input logic [15:0] a,
                                            input logic [2:0] s, input int amt);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      case (s)
        3'b001:  r[i] = (i >= amt) ? a[i-amt] : 1'b0;
        3'b010:  r[i] = (i + amt < n) ? a[i+amt] : 1'b0;
        3'b011:  r[i] = (i + amt < n) ? a[i+amt] : a[n-1];
        3'b100:  r[i] = a[(i - amt + n) % n];
        3'b101:  r[i] = a[(i + amt) % n];
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  // Monitors: pop and compare on every output transfer; check hold while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov8 && or8) begin
        if (q8.size() == 0) fail_now("m8_spurious_output");
        else begin
          e8 = q8.pop_front();
          $display("n8  out Z=%02h ZF=%0b exp=%02h", z8, zf8, e8.z[7:0]);
          check("m8_z", {24'h0, z8}, {24'h0, e8.z[7:0]});
          check("m8_zf", {31'h0, zf8}, {31'h0, (e8.z[7:0] == 8'h00)});
          if (e8.lat) check("m8_latency", cyc - e8.acc, 3);
          xfer8++;
        end
      end else if (ov8 && !or8 && q8.size() > 0) begin
        check("m8_hold_z", {24'h0, z8}, {24'h0, q8[0].z[7:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4 && or4) begin
      if (q4.size() == 0) fail_now("m4_spurious_output");
      else begin
        e4 = q4.pop_front();
        check("m4_z", {28'h0, z4}, {28'h0, e4.z[3:0]});
        check("m4_zf", {31'h0, zf4}, {31'h0, (e4.z[3:0] == 4'h0)});
        if (e4.lat) check("m4_latency", cyc - e4.acc, 2);
        xfer4++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16 && or16) begin
      if (q16.size() == 0) fail_now("m16_spurious_output");
      else begin
        e16 = q16.pop_front();
        $display("n16 out Z=%04h ZF=%0b exp=%04h", z16, zf16, e16.z);
        check("m16_z", {16'h0, z16}, {16'h0, e16.z});
        check("m16_zf", {31'h0, zf16}, {31'h0, (e16.z == 16'h0)});
        if (e16.lat) check("m16_latency", cyc - e16.acc, 4);
        xfer16++;
      end
    end
  end

  // Drivers: called at posedge+1; hold the operand until accepted.
  task automatic send8(input logic [7:0] a, input logic [2:0] s, input logic [2:0] amt,
                       input logic [7:0] exp, input bit lat);
    exp_t e;
    int   n;
    bit   done;
    a8 = a; s8 = s; amt8 = amt; iv8 = 1'b1; n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (ir8) begin
        e.z = {8'h00, exp}; e.acc = cyc; e.lat = lat;
        q8.push_back(e);
        acc8++;
        done = 1'b1;
        $display("n8  in  A=%02h S=%0d AMT=%0d exp=%02h", a, s, amt, exp);
      end else if (++n > 200) begin
        fail_now("send8_accept");
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
  endtask

  // Presents an operand for exactly one cycle; pushes only if accepted.
  task automatic try8(input logic [7:0] a, input logic [2:0] s, input logic [2:0] amt,
                      input logic [7:0] exp);
    exp_t e;
    a8 = a; s8 = s; amt8 = amt; iv8 = 1'b1;
    @(negedge clk);
    if (ir8) begin
      e.z = {8'h00, exp}; e.acc = cyc; e.lat = 1'b0;
      q8.push_back(e);
      acc8++;
    end
    $display("n8  try A=%02h S=%0d AMT=%0d ready=%0b", a, s, amt, ir8);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [2:0] s, input logic [1:0] amt);
    exp_t e;
    a4 = a; s4 = s; amt4 = amt; iv4 = 1'b1;
    @(negedge clk);
    if (ir4) begin
      e.z = ref_shift(4, {12'h0, a}, s, int'(amt)); e.acc = cyc; e.lat = 1'b1;
      q4.push_back(e);
    end else fail_now("send4_ready");
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [2:0] s, input logic [3:0] amt,
                        input logic [15:0] exp);
    exp_t e;
    a16 = a; s16 = s; amt16 = amt; iv16 = 1'b1;
    @(negedge clk);
    if (ir16) begin
      e.z = exp; e.acc = cyc; e.lat = 1'b1;
      q16.push_back(e);
      $display("n16 in  A=%04h S=%0d AMT=%0d exp=%04h", a, s, amt, exp);
    end else fail_now("send16_ready");
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q8.size() + q4.size() + q16.size()) != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) fail_now(nm);
  endtask

  bit rand_rdy = 1'b0;
  initial forever begin
    @(posedge clk); #2;
    if (rand_rdy) or8 = 1'($urandom_range(0, 1));
  end

  // Directed N=8 vectors with hand-computed results.
  localparam int NV = 13;
  logic [7:0] va [NV] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96,
                          8'h96, 8'h96, 8'h01, 8'h80, 8'h7F, 8'hF0};
  logic [2:0] vs [NV] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd0,
                          3'd1, 3'd1, 3'd5, 3'd3, 3'd3, 3'd4};
  logic [2:0] vm [NV] = '{3'd3, 3'd4, 3'd2, 3'd1, 3'd7, 3'd5, 3'd5,
                          3'd0, 3'd7, 3'd1, 3'd7, 3'd3, 3'd4};
  logic [7:0] vz [NV] = '{8'hB0, 8'h09, 8'hE5, 8'h4B, 8'h4B, 8'h96, 8'h96,
                          8'h96, 8'h00, 8'h80, 8'hFF, 8'h0F, 8'h0F};

  initial begin
    int x8;
    rst = 1'b1;
    iv8 = 0; a8 = 0; s8 = 0; amt8 = 0; or8 = 1;
    iv4 = 0; a4 = 0; s4 = 0; amt4 = 0; or4 = 1;
    iv16 = 0; a16 = 0; s16 = 0; amt16 = 0; or16 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'h0, ov8}, 32'h0);
    check("reset_z", {24'h0, z8}, 32'h0);
    check("reset_zf", {31'h0, zf8}, 32'h1);
    check("reset_in_ready", {31'h0, ir8}, 32'h1);
    check("reset_zf16", {31'h0, zf16}, 32'h1);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors streamed back-to-back with out_ready high.
    for (int i = 0; i < NV; i++) send8(va[i], vs[i], vm[i], vz[i], 1'b1);
    drain("drain_directed");

    // N=16 parameter check.
    send16(16'h8001, MODE_SRA, 4'd15, 16'hFFFF);
    send16(16'h8001, MODE_ROL, 4'd1,  16'h0003);
    send16(16'h8001, MODE_ROR, 4'd1,  16'hC000);
    send16(16'h8001, MODE_SLL, 4'd15, 16'h8000);
    send16(16'h8001, MODE_SRL, 4'd15, 16'h0001);
    drain("drain_n16");

    // Exhaustive N=4 sweep, one operand per cycle.
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 16; a++)
        for (int m = 0; m < 4; m++)
          send4(4'(a), 3'(s), 2'(m));
    drain("drain_sweep");
    check("sweep_count", xfer4, 512);
    $display("n4  sweep done transfers=%0d", xfer4);

    // Backpressure: 5 one-shot offers into a stalled pipe, only 3 fit.
    or8 = 1'b0;
    acc8 = 0;
    x8 = xfer8;
    try8(8'h96, MODE_SLL, 3'd1, 8'h2C);
    try8(8'h96, MODE_SRL, 3'd1, 8'h4B);
    try8(8'h96, MODE_SRA, 3'd1, 8'hCB);
    try8(8'h96, MODE_ROL, 3'd1, 8'h2D);
    try8(8'h96, MODE_ROR, 3'd2, 8'hA5);
    check("bp_accepted", acc8, 3);
    check("bp_in_ready_low", {31'h0, ir8}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_z", {24'h0, z8}, 32'h2C);
    or8 = 1'b1;
    drain("drain_backpressure");
    check("bp_transfers", xfer8 - x8, 3);

    // Bubbles with random backpressure.
    acc8 = 0;
    x8 = xfer8;
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send8(va[i+5], vs[i+5], vm[i+5], vz[i+5], 1'b0);
      @(posedge clk); #1;
    end
    rand_rdy = 1'b0;
    or8 = 1'b1;
    drain("drain_bubbles");
    check("bubble_transfers", xfer8 - x8, acc8);

    // Reset with three operands in flight.
    send8(8'h96, MODE_SLL, 3'd3, 8'hB0, 1'b0);
    send8(8'h96, MODE_SRL, 3'd4, 8'h09, 1'b0);
    send8(8'h96, MODE_SRA, 3'd2, 8'hE5, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'h0, ov8}, 32'h0);
    check("midrst_z", {24'h0, z8}, 32'h0);
    check("midrst_zf", {31'h0, zf8}, 32'h1);
    q8.delete();
    q4.delete();
    q16.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    send8(8'h96, MODE_ROR, 3'd1, 8'h4B, 1'b1);
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
